dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single data-memory port between the pipeline MEM stage and a debug/DMA requester. The pipeline has default priority. The debug port uses a valid/ready handshake and gets a guaranteed grant after a bounded wait, or exclusive ownership through a lock. The block sits between the EX/MEM pipeline register outputs and the data memory, and returns a stall request to the hazard logic.

Parameters:
DATA_W, 32, data width
DM_ADDRESS, 9, data memory address width
MAX_WAIT, 8, consecutive denied debug-request cycles before a forced grant (1..255)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
p_rd  in  1  pipeline load request (MEM stage)
p_wr  in  1  pipeline store request
p_addr  in  DM_ADDRESS  pipeline address
p_wdata  in  DATA_W  pipeline store data
p_funct3  in  3  pipeline access size/sign
p_stall  out  1  pipeline must hold MEM stage and upstream this cycle
p_rdata  out  DATA_W  load data, valid the cycle after a granted p_rd
d_valid  in  1  debug request valid
d_we  in  1  1 = write, 0 = read
d_addr  in  DM_ADDRESS  debug address
d_wdata  in  DATA_W  debug write data
d_funct3  in  3  debug access size/sign
d_lock  in  1  with a granted access: keep exclusive ownership afterwards
d_ready  out  1  debug access issued this cycle (handshake = d_valid & d_ready)
d_rvalid  out  1  d_rdata valid (1 cycle after a granted debug read)
d_rdata  out  DATA_W  debug read data
mem_rd  out  1  to data memory
mem_wr  out  1  to data memory
mem_addr  out  DM_ADDRESS  to data memory
mem_wdata  out  DATA_W  to data memory
mem_funct3  out  3  to data memory
mem_rdata  in  DATA_W  memory read data, registered, 1-cycle latency

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, wait_cnt=0, d_rvalid=0, rd-owner flag=0.
- Outputs during reset: p_stall=0, d_ready=0. The mem_* outputs follow the IDLE mux, which is combinational from the pipeline inputs.
- Any debug read in flight is dropped and no d_rvalid is produced for it.
- The memory-side mux is combinational from the current-cycle owner. The owner decision itself is combinational from state and requests.
- State IDLE:
  - If p_rd|p_wr: the pipeline owns the port, d_ready=0, p_stall=0.
  - Else if d_valid: debug owns the port, d_ready=1.
  - Else: mem_rd=mem_wr=0.
- wait_cnt: increments each cycle d_valid&!d_ready, saturating at MAX_WAIT. It clears on any debug handshake or when d_valid=0.
- IDLE -> FORCE: when wait_cnt reaches MAX_WAIT while d_valid stays high (registered transition).
- State FORCE: debug owns the port, d_ready=1, p_stall=1 (combinational, even if the pipeline has no request).
  - On the handshake: to LOCK if d_lock=1, else to IDLE.
  - If d_valid drops: back to IDLE with no access.
- IDLE handshake with d_lock=1: next state is LOCK.
- State LOCK:
  - p_stall=1 every cycle; debug owns the port; d_ready=d_valid.
  - Exits to IDLE on the first cycle with d_lock=0. That cycle still grants any valid debug access; p_stall is deasserted from the next cycle.
- Read return: a registered flag records whether the current cycle's read is a debug read.
  - Next cycle: d_rvalid=1 and d_rdata=mem_rdata for a debug read.
  - p_rdata=mem_rdata always; the pipeline only samples it after a granted p_rd.
- Writes complete in the issue cycle; no response is returned.
- A stalled pipeline keeps p_rd/p_wr/p_addr stable. The arbiter never issues a stalled pipeline access.
- Simultaneous p_rd and p_wr is illegal: mem_wr wins and mem_rd=0.
- Simultaneous pipeline request and FORCE/LOCK: debug always wins; the pipeline is retried after release.
- Debug inputs must stay stable while d_valid&!d_ready. They may change after the handshake.

Test Plan:
1. Reset low mid debug read -> d_rvalid stays 0, state IDLE, p_stall=0; after release, a pipeline load at addr 0x010 gets mem_rd=1 the same cycle.
2. Pipeline idle, d_valid read addr 0x020 (mem holds 0xDEADBEEF) -> d_ready=1 the same cycle; d_rvalid=1 and d_rdata=0xDEADBEEF the next cycle.
3. Pipeline stores every cycle with d_valid write held, MAX_WAIT=8 -> denied 8 cycles; cycle 9 p_stall=1, mem_wr from debug, d_ready=1; cycle 10 pipeline resumes with p_stall=0.
4. Debug write with d_lock=1, then 3 debug reads, then d_lock=0 -> p_stall=1 throughout; the pipeline load issued after release returns the correct data.
5. Debug read granted in cycle N, pipeline load granted in cycle N+1 -> d_rvalid in N+1 only; p_rdata in N+2 holds the pipeline data.
6. p_rd=p_wr=1 -> mem_wr=1, mem_rd=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Data-memory sharing bundle: pipeline MEM stage, debug/DMA port and memory side.
// The arbiter takes the slave view; requesters and memory take the master view.
interface dmem_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9
);
  logic                  p_rd;
  logic                  p_wr;
  logic [DM_ADDRESS-1:0] p_addr;
  logic [DATA_W-1:0]     p_wdata;
  logic [2:0]            p_funct3;
  logic                  p_stall;
  logic [DATA_W-1:0]     p_rdata;

  logic                  d_valid;
  logic                  d_we;
  logic [DM_ADDRESS-1:0] d_addr;
  logic [DATA_W-1:0]     d_wdata;
  logic [2:0]            d_funct3;
  logic                  d_lock;
  logic                  d_ready;
  logic                  d_rvalid;
  logic [DATA_W-1:0]     d_rdata;

  logic                  mem_rd;
  logic                  mem_wr;
  logic [DM_ADDRESS-1:0] mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [2:0]            mem_funct3;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  p_rd, p_wr, p_addr, p_wdata, p_funct3,
    output p_stall, p_rdata,
    input  d_valid, d_we, d_addr, d_wdata, d_funct3, d_lock,
    output d_ready, d_rvalid, d_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    input  mem_rdata
  );

  modport master (
    output p_rd, p_wr, p_addr, p_wdata, p_funct3,
    input  p_stall, p_rdata,
    output d_valid, d_we, d_addr, d_wdata, d_funct3, d_lock,
    input  d_ready, d_rvalid, d_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, mem_funct3,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter: pipeline has priority, debug gets a bounded-wait
// forced grant or exclusive ownership through a lock.
module dmem_arbiter #(
  parameter int DATA_W     = 32,
  parameter int DM_ADDRESS = 9,
  parameter int MAX_WAIT   = 8
) (
  input  logic          clk,
  input  logic          reset,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    FORCE,
    LOCK
  } state_t;

  localparam logic [7:0] MAXW = 8'(MAX_WAIT);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] wait_cnt;
  logic [7:0] wait_nxt;
  logic       rd_dbg;

  logic dv;
  logic preq;
  logic dbg_own;
  logic pipe_own;
  logic ready;
  logic stall;
  logic hs;

  // No debug grant is possible while reset is held.
  assign dv   = bus.d_valid & reset;
  assign preq = bus.p_rd | bus.p_wr;
  assign hs   = dv & ready;

  always_comb begin
    dbg_own  = 1'b0;
    pipe_own = 1'b0;
    ready    = 1'b0;
    stall    = 1'b0;
    unique case (state)
      IDLE: begin
        if (preq) begin
          pipe_own = 1'b1;
        end else if (dv) begin
          dbg_own = 1'b1;
          ready   = 1'b1;
        end
      end
      FORCE: begin
        dbg_own = 1'b1;
        ready   = 1'b1;
        stall   = 1'b1;
      end
      LOCK: begin
        dbg_own = 1'b1;
        ready   = dv;
        stall   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_nxt = wait_cnt;
    if (!dv || hs) begin
      wait_nxt = '0;
    end else if (wait_cnt != MAXW) begin
      wait_nxt = wait_cnt + 8'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (hs && bus.d_lock) begin
          state_nxt = LOCK;
        end else if (dv && !ready && wait_nxt == MAXW) begin
          state_nxt = FORCE;
        end
      end
      FORCE: begin
        if (!dv) begin
          state_nxt = IDLE;
        end else if (hs) begin
          state_nxt = bus.d_lock ? LOCK : IDLE;
        end
      end
      LOCK: begin
        if (!bus.d_lock) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      wait_cnt <= '0;
      rd_dbg   <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      rd_dbg   <= hs & ~bus.d_we;
    end
  end

  // A simultaneous pipeline load and store resolves to the store.
  assign bus.mem_wr = pipe_own ? bus.p_wr
                               : dbg_own & dv & bus.d_we;
  assign bus.mem_rd = pipe_own ? bus.p_rd & ~bus.p_wr
                               : dbg_own & dv & ~bus.d_we;

  assign bus.mem_addr   = dbg_own ? bus.d_addr   : bus.p_addr;
  assign bus.mem_wdata  = dbg_own ? bus.d_wdata  : bus.p_wdata;
  assign bus.mem_funct3 = dbg_own ? bus.d_funct3 : bus.p_funct3;

  assign bus.p_stall  = stall;
  assign bus.d_ready  = ready;
  assign bus.d_rvalid = rd_dbg;
  assign bus.d_rdata  = bus.mem_rdata;
  assign bus.p_rdata  = bus.mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios plus randomized traffic
// against a rule-level reference model and a behavioural memory.
module tb_dmem_arbiter;

  localparam int MAXW = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  dmem_arbiter_if #(.DATA_W(32), .DM_ADDRESS(9)) bus ();

  dmem_arbiter #(.DATA_W(32), .DM_ADDRESS(9), .MAX_WAIT(MAXW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [512];
  logic [31:0] ref_mem [512];
  logic [31:0] rdata_q = 32'h0;

  // Registered-read memory, one cycle latency.
  always @(posedge clk) begin
    if (bus.mem_rd) rdata_q <= mem[bus.mem_addr];
    if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
  end

  assign bus.mem_rdata = rdata_q;

  task automatic idle_inputs();
    bus.p_rd = 0; bus.p_wr = 0; bus.p_addr = '0;
    bus.p_wdata = '0; bus.p_funct3 = 3'd2;
    bus.d_valid = 0; bus.d_we = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_funct3 = 3'd2; bus.d_lock = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    next_cycle();
    bus.d_valid = 1; bus.d_we = 0; bus.d_addr = 9'h020;
    @(negedge clk);
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL rst_pre_ready got=%b want=1", bus.d_ready); end
    #1;
    reset = 0;
    bus.p_rd = 1; bus.p_addr = 9'h010;
    #1;
    checks++; if (bus.d_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b want=0", bus.d_ready); end
    checks++; if (bus.p_stall !== 1'b0) begin failures++; $display("FAIL rst_stall got=%b want=0", bus.p_stall); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h010) begin failures++; $display("FAIL rst_mux rd=%b addr=%h want rd=1 addr=010", bus.mem_rd, bus.mem_addr); end
    @(posedge clk);
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b want=0", bus.d_rvalid); end
    next_cycle();
    reset = 1; bus.d_valid = 0;
    @(negedge clk);
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h010) begin failures++; $display("FAIL post_rst_load rd=%b addr=%h want rd=1 addr=010", bus.mem_rd, bus.mem_addr); end
    checks++; if (bus.p_stall !== 1'b0 || bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL post_rst_flags stall=%b rvalid=%b want 0 0", bus.p_stall, bus.d_rvalid); end
    next_cycle();
    bus.p_rd = 0;
    @(negedge clk);
    checks++; if (bus.p_rdata !== 32'hC0DE0010) begin failures++; $display("FAIL post_rst_rdata got=%h want=c0de0010", bus.p_rdata); end
  endtask

  task automatic test_debug_read();
    next_cycle();
    bus.d_valid = 1; bus.d_we = 0; bus.d_addr = 9'h020;
    @(negedge clk);
    checks++; if (bus.d_ready !== 1'b1 || bus.mem_rd !== 1'b1) begin failures++; $display("FAIL dbg_rd_issue ready=%b rd=%b want 1 1", bus.d_ready, bus.mem_rd); end
    checks++; if (bus.mem_addr !== 9'h020) begin failures++; $display("FAIL dbg_rd_addr got=%h want=020", bus.mem_addr); end
    next_cycle();
    bus.d_valid = 0;
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL dbg_rd_data rvalid=%b data=%h want 1 deadbeef", bus.d_rvalid, bus.d_rdata); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b0) begin failures++; $display("FAIL dbg_rd_once got=%b want=0", bus.d_rvalid); end
  endtask

  task automatic test_force();
    next_cycle();
    bus.d_valid = 1; bus.d_we = 1; bus.d_addr = 9'h030;
    bus.d_wdata = 32'h12345678; bus.d_lock = 0;
    bus.p_wr = 1; bus.p_addr = 9'h100; bus.p_wdata = 32'h0;
    for (int k = 0; k < MAXW; k++) begin
      @(negedge clk);
      checks++; if (bus.d_ready !== 1'b0 || bus.p_stall !== 1'b0) begin failures++; $display("FAIL force_deny k=%0d ready=%b stall=%b want 0 0", k, bus.d_ready, bus.p_stall); end
      checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'(9'h100 + k)) begin failures++; $display("FAIL force_pipe k=%0d wr=%b addr=%h want 1 %h", k, bus.mem_wr, bus.mem_addr, 9'(9'h100 + k)); end
      next_cycle();
      bus.p_addr = 9'(9'h101 + k); bus.p_wdata = 32'(k + 1);
    end
    @(negedge clk);
    checks++; if (bus.p_stall !== 1'b1 || bus.d_ready !== 1'b1) begin failures++; $display("FAIL force_grant stall=%b ready=%b want 1 1", bus.p_stall, bus.d_ready); end
    checks++; if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'h030 || bus.mem_wdata !== 32'h12345678) begin failures++; $display("FAIL force_dbg_wr wr=%b addr=%h data=%h want 1 030 12345678", bus.mem_wr, bus.mem_addr, bus.mem_wdata); end
    next_cycle();
    bus.d_valid = 0;
    @(negedge clk);
    checks++; if (bus.p_stall !== 1'b0 || bus.mem_wr !== 1'b1 || bus.mem_addr !== 9'h108) begin failures++; $display("FAIL force_resume stall=%b wr=%b addr=%h want 0 1 108", bus.p_stall, bus.mem_wr, bus.mem_addr); end
    next_cycle();
    bus.p_wr = 0;
  endtask

  task automatic test_lock();
    bus.d_valid = 1; bus.d_we = 1; bus.d_addr = 9'h040;
    bus.d_wdata = 32'hA5A50001; bus.d_lock = 1;
    @(negedge clk);
    checks++; if (bus.d_ready !== 1'b1 || bus.mem_wr !== 1'b1 || bus.p_stall !== 1'b0) begin failures++; $display("FAIL lock_wr ready=%b wr=%b stall=%b want 1 1 0", bus.d_ready, bus.mem_wr, bus.p_stall); end
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      bus.p_rd = 1; bus.p_addr = 9'h040;
      bus.d_we = 0; bus.d_addr = 9'(9'h041 + i);
      @(negedge clk);
      checks++; if (bus.p_stall !== 1'b1 || bus.d_ready !== 1'b1) begin failures++; $display("FAIL lock_hold i=%0d stall=%b ready=%b want 1 1", i, bus.p_stall, bus.d_ready); end
      checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'(9'h041 + i)) begin failures++; $display("FAIL lock_rd i=%0d rd=%b addr=%h want 1 %h", i, bus.mem_rd, bus.mem_addr, 9'(9'h041 + i)); end
      if (i > 0) begin
        checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'(32'hC0DE0040 + i)) begin failures++; $display("FAIL lock_rdata i=%0d rvalid=%b data=%h want 1 %h", i, bus.d_rvalid, bus.d_rdata, 32'(32'hC0DE0040 + i)); end
      end
    end
    next_cycle();
    bus.d_valid = 0; bus.d_lock = 0;
    @(negedge clk);
    checks++; if (bus.p_stall !== 1'b1 || bus.mem_rd !== 1'b0) begin failures++; $display("FAIL lock_release stall=%b rd=%b want 1 0", bus.p_stall, bus.mem_rd); end
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hC0DE0043) begin failures++; $display("FAIL lock_last rvalid=%b data=%h want 1 c0de0043", bus.d_rvalid, bus.d_rdata); end
    next_cycle();
    @(negedge clk);
    checks++; if (bus.p_stall !== 1'b0 || bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h040) begin failures++; $display("FAIL lock_pipe stall=%b rd=%b addr=%h want 0 1 040", bus.p_stall, bus.mem_rd, bus.mem_addr); end
    next_cycle();
    bus.p_rd = 0;
    @(negedge clk);
    checks++; if (bus.p_rdata !== 32'hA5A50001) begin failures++; $display("FAIL lock_pipe_data got=%h want=a5a50001", bus.p_rdata); end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    bus.d_valid = 1; bus.d_we = 0; bus.d_addr = 9'h050;
    @(negedge clk);
    checks++; if (bus.d_ready !== 1'b1) begin failures++; $display("FAIL b2b_dbg_ready got=%b want=1", bus.d_ready); end
    next_cycle();
    bus.d_valid = 0; bus.p_rd = 1; bus.p_addr = 9'h051;
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hC0DE0050) begin failures++; $display("FAIL b2b_dbg_data rvalid=%b data=%h want 1 c0de0050", bus.d_rvalid, bus.d_rdata); end
    checks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== 9'h051) begin failures++; $display("FAIL b2b_pipe_issue rd=%b addr=%h want 1 051", bus.mem_rd, bus.mem_addr); end
    next_cycle();
    bus.p_rd = 0;
    @(negedge clk);
    checks++; if (bus.d_rvalid !== 1'b0 || bus.p_rdata !== 32'hC0DE0051) begin failures++; $display("FAIL b2b_pipe_data rvalid=%b data=%h want 0 c0de0051", bus.d_rvalid, bus.p_rdata); end
  endtask

  task automatic test_rd_wr_conflict();
    next_cycle();
    bus.p_rd = 1; bus.p_wr = 1; bus.p_addr = 9'h060; bus.p_wdata = 32'h60606060;
    @(negedge clk);
    checks++; if (bus.mem_wr !== 1'b1 || bus.mem_rd !== 1'b0) begin failures++; $display("FAIL conflict wr=%b rd=%b want 1 0", bus.mem_wr, bus.mem_rd); end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_random();
    bit locked = 0, forced = 0;
    int denied = 0;
    bit hold_p = 0, hold_d = 0;
    bit exp_rv = 0, exp_pv = 0;
    logic [31:0] exp_dd = '0, exp_pd = '0;
    bit preq, dbg_owns, e_ready, e_stall, dgrant, pgrant, e_rd, e_wr;
    logic [8:0] e_addr;
    logic [31:0] e_wdata;
    logic [2:0] e_f3;
    int r;
    next_cycle();
    idle_inputs();
    reset = 0;
    next_cycle();
    reset = 1;
    for (int i = 0; i < 512; i++) ref_mem[i] = mem[i];
    for (int n = 0; n < 2000; n++) begin
      if (!hold_p) begin
        r = $urandom_range(0, 9);
        bus.p_rd = (r < 4); bus.p_wr = (r >= 4 && r < 8);
        bus.p_addr = 9'($urandom_range(0, 31));
        bus.p_wdata = $urandom; bus.p_funct3 = 3'($urandom_range(0, 7));
      end
      if (!hold_d) begin
        bus.d_valid = ($urandom_range(0, 1) == 1);
        bus.d_we = ($urandom_range(0, 1) == 1);
        bus.d_addr = 9'($urandom_range(0, 31));
        bus.d_wdata = $urandom; bus.d_funct3 = 3'($urandom_range(0, 7));
        bus.d_lock = ($urandom_range(0, 3) == 0);
      end
      @(negedge clk);
      preq = bus.p_rd | bus.p_wr;
      dbg_owns = locked || forced || !preq;
      e_stall = locked || forced;
      e_ready = locked ? bus.d_valid : (forced ? 1'b1 : (!preq && bus.d_valid));
      dgrant = dbg_owns && bus.d_valid && e_ready;
      pgrant = !dbg_owns;
      e_wr = pgrant ? bus.p_wr : (dgrant && bus.d_we);
      e_rd = pgrant ? (bus.p_rd && !bus.p_wr) : (dgrant && !bus.d_we);
      e_addr = pgrant ? bus.p_addr : bus.d_addr;
      e_wdata = pgrant ? bus.p_wdata : bus.d_wdata;
      e_f3 = pgrant ? bus.p_funct3 : bus.d_funct3;
      checks++; if (bus.p_stall !== e_stall) begin failures++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, bus.p_stall, e_stall); end
      checks++; if (bus.d_ready !== e_ready) begin failures++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, bus.d_ready, e_ready); end
      checks++; if (bus.mem_rd !== e_rd || bus.mem_wr !== e_wr) begin failures++; $display("FAIL rnd_cmd n=%0d rd=%b wr=%b want %b %b", n, bus.mem_rd, bus.mem_wr, e_rd, e_wr); end
      if (e_rd || e_wr) begin
        checks++; if (bus.mem_addr !== e_addr || bus.mem_funct3 !== e_f3) begin failures++; $display("FAIL rnd_addr n=%0d addr=%h f3=%h want %h %h", n, bus.mem_addr, bus.mem_funct3, e_addr, e_f3); end
      end
      if (e_wr) begin
        checks++; if (bus.mem_wdata !== e_wdata) begin failures++; $display("FAIL rnd_wdata n=%0d got=%h want=%h", n, bus.mem_wdata, e_wdata); end
      end
      checks++; if (bus.d_rvalid !== exp_rv) begin failures++; $display("FAIL rnd_rvalid n=%0d got=%b want=%b", n, bus.d_rvalid, exp_rv); end
      if (exp_rv) begin
        checks++; if (bus.d_rdata !== exp_dd) begin failures++; $display("FAIL rnd_drdata n=%0d got=%h want=%h", n, bus.d_rdata, exp_dd); end
      end
      if (exp_pv) begin
        checks++; if (bus.p_rdata !== exp_pd) begin failures++; $display("FAIL rnd_prdata n=%0d got=%h want=%h", n, bus.p_rdata, exp_pd); end
      end
      exp_rv = dgrant && !bus.d_we;
      exp_pv = pgrant && e_rd;
      exp_dd = ref_mem[e_addr];
      exp_pd = ref_mem[e_addr];
      if (e_wr) ref_mem[e_addr] = e_wdata;
      if (locked) begin
        locked = bus.d_lock;
      end else if (forced) begin
        forced = 0;
        if (dgrant) locked = bus.d_lock;
      end else if (dgrant) begin
        locked = bus.d_lock;
      end else if (bus.d_valid && denied + 1 >= MAXW) begin
        forced = 1;
      end
      if (!bus.d_valid || dgrant) denied = 0;
      else if (denied < MAXW) denied++;
      hold_p = e_stall && preq;
      hold_d = bus.d_valid && !e_ready;
      next_cycle();
    end
    idle_inputs();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'hC0DE0000 | 32'(i);
    mem[32'h20] = 32'hDEADBEEF;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1;
    test_reset();
    test_debug_read();
    test_force();
    test_lock();
    test_back_to_back();
    test_rd_wr_conflict();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
